mem_req_queue: RTL and testbench

- Request-side front end for the `mem` block; sits directly upstream of it.
- Accepts write/read requests from a producer over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drives the memory's valid_i/wr_rd_i/addr_i/wr_data_i/ready_o handshake and returns read data as a single-cycle response pulse.

---
 rtl/mem_req_queue_pkg.sv | 23 ++
 rtl/mem_req_if.sv | 44 ++++
 rtl/mem_req_queue_fifo.sv | 52 +++++
 rtl/mem_req_queue.sv | 138 +++++++++++++
 tb/tb_mem_req_queue.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_queue_pkg.sv
// Shared types for the memory request queue: FSM states, request direction
// constants and the default FIFO entry layout.
package mem_req_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_ADDR_WIDTH = 4;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RD_WAIT
  } state_t;

  typedef struct packed {
    logic                      wr_rd;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_WIDTH-1:0]      wr_data;
  } req_t;

endpackage

// File: rtl/mem_req_if.sv
// Producer, memory and response signals of the request queue, bundled with
// a slave view (the queue) and a master view (producer plus memory side).
interface mem_req_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int Q_DEPTH    = 4
);
  localparam int CW = $clog2(Q_DEPTH) + 1;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both 1; once valid is raised its payload holds until that edge.
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_wr_rd_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [WIDTH-1:0]      req_wr_data_i;

  logic                  mem_valid_o;
  logic                  mem_ready_i;
  logic                  mem_wr_rd_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [WIDTH-1:0]      mem_wr_data_o;
  logic [WIDTH-1:0]      mem_rd_data_i;

  logic                  rsp_valid_o;
  logic [ADDR_WIDTH-1:0] rsp_addr_o;
  logic [WIDTH-1:0]      rsp_data_o;
  logic [CW-1:0]         count_o;

  modport slave (
    input  req_valid_i, req_wr_rd_i, req_addr_i, req_wr_data_i,
    input  mem_ready_i, mem_rd_data_i,
    output req_ready_o, mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wr_data_o,
    output rsp_valid_o, rsp_addr_o, rsp_data_o, count_o
  );

  modport master (
    output req_valid_i, req_wr_rd_i, req_addr_i, req_wr_data_i,
    output mem_ready_i, mem_rd_data_i,
    input  req_ready_o, mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wr_data_o,
    input  rsp_valid_o, rsp_addr_o, rsp_data_o, count_o
  );

endinterface

// File: rtl/mem_req_queue_fifo.sv
// In-order request FIFO with occupancy count; head entry is read
// combinationally, pushes are refused while full even if a pop coincides.
module mem_req_fifo
  import mem_req_pkg::*;
#(
  parameter type entry_t = req_t,
  parameter int  DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 din,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_req_queue.sv
// Request queue in front of the mem block: buffers producer requests, issues
// them in order and returns read data as a one-cycle response pulse.
// Optional MEM_REQ_QUEUE_STATS_EN adds saturating write/read pop counters.
module mem_req_queue
  import mem_req_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int Q_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  mem_req_if.slave    bus,
  output state_t      fsm_state
`ifdef MEM_REQ_QUEUE_STATS_EN
  ,
  output logic [15:0] wr_cnt_o,
  output logic [15:0] rd_cnt_o
`endif
);
  localparam int CW = $clog2(Q_DEPTH) + 1;

  // Same layout as req_t, sized to this instance's widths.
  typedef struct packed {
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wr_data;
  } entry_t;

  entry_t                din;
  entry_t                head;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  push_fire;
  logic                  mem_fire;
  logic                  mem_valid;
  logic                  rd_pop;
  state_t                state_q;
  state_t                state_d;
  logic                  rsp_valid_q;
  logic [ADDR_WIDTH-1:0] rsp_addr_q;
  logic [WIDTH-1:0]      rsp_data_q;

  assign din.wr_rd   = bus.req_wr_rd_i;
  assign din.addr    = bus.req_addr_i;
  assign din.wr_data = bus.req_wr_data_i;
  assign push_fire   = bus.req_valid_i && !full;
  assign mem_fire    = mem_valid && bus.mem_ready_i;

  mem_req_fifo #(
    .entry_t (entry_t),
    .DEPTH   (Q_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.req_valid_i),
    .din   (din),
    .pop   (mem_fire),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_valid = 1'b0;
    rd_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) state_d = ISSUE;
      end
      ISSUE: begin
        mem_valid = 1'b1;
        if (bus.mem_ready_i) begin
          if (head.wr_rd == RD) begin
            rd_pop  = 1'b1;
            state_d = RD_WAIT;
          end else if (count > CW'(1) || push_fire) begin
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RD_WAIT: begin
        state_d = empty ? IDLE : ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is valid during RD_WAIT; it is registered into the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= (state_q == RD_WAIT);
      if (rd_pop)              rsp_addr_q <= head.addr;
      if (state_q == RD_WAIT)  rsp_data_q <= bus.mem_rd_data_i;
    end
  end

  assign bus.req_ready_o   = !full;
  assign bus.count_o       = count;
  assign bus.mem_valid_o   = mem_valid;
  assign bus.mem_wr_rd_o   = mem_valid ? head.wr_rd : 1'b0;
  assign bus.mem_addr_o    = mem_valid ? head.addr : '0;
  assign bus.mem_wr_data_o = (mem_valid && head.wr_rd == WR) ? head.wr_data : '0;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_addr_o    = rsp_addr_q;
  assign bus.rsp_data_o    = rsp_data_q;
  assign fsm_state         = state_q;

`ifdef MEM_REQ_QUEUE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_o <= '0;
      rd_cnt_o <= '0;
    end else if (mem_fire) begin
      if (head.wr_rd == WR) begin
        if (wr_cnt_o != 16'hFFFF) wr_cnt_o <= wr_cnt_o + 16'd1;
      end else begin
        if (rd_cnt_o != 16'hFFFF) rd_cnt_o <= rd_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue with a behavioural memory model, a read
// response scoreboard and a log of memory-side transfers.
module tb_mem_req_queue;
  import mem_req_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_req_if #(.WIDTH(16), .ADDR_WIDTH(4), .Q_DEPTH(4)) bus ();
  state_t fsm_state;
`ifdef MEM_REQ_QUEUE_STATS_EN
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;
`endif

  mem_req_queue #(.WIDTH(16), .ADDR_WIDTH(4), .Q_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
`ifdef MEM_REQ_QUEUE_STATS_EN
    ,
    .wr_cnt_o  (wr_cnt),
    .rd_cnt_o  (rd_cnt)
`endif
  );

  // ---------------- memory model: read data valid the cycle after acceptance ----------------
  logic [15:0] mem_model [16];
  logic        mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 16; i++) mem_model[i] <= 16'h1000 + 16'(i);
      mem_init_done <= 1'b1;
    end else if (bus.mem_valid_o && bus.mem_ready_i) begin
      if (bus.mem_wr_rd_o) mem_model[bus.mem_addr_o] <= bus.mem_wr_data_o;
      else                 bus.mem_rd_data_i <= mem_model[bus.mem_addr_o];
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- scoreboard / monitors ----------------
  logic [19:0] exp_q[$];
  int          cyc     = 0;
  int          rsp_cnt = 0;
  int          rsp_cyc = 0;
  int          fire_cyc[$];
  logic [3:0]  fire_addr[$];
  logic        fire_wr[$];
  logic [15:0] fire_data[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.rsp_valid_o) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      if (exp_q.size() > 0) begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("rsp_addr", 32'(bus.rsp_addr_o), 32'(e[19:16]));
        check("rsp_data", 32'(bus.rsp_data_o), 32'(e[15:0]));
      end else begin
        check("rsp_unexpected", 32'(1), 32'(0));
      end
    end
    if (bus.mem_valid_o && bus.mem_ready_i) begin
      fire_cyc.push_back(cyc);
      fire_addr.push_back(bus.mem_addr_o);
      fire_wr.push_back(bus.mem_wr_rd_o);
      fire_data.push_back(bus.mem_wr_data_o);
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic push_req(input logic wr, input logic [3:0] addr, input logic [15:0] data);
    logic ok;
    ok = 1'b0;
    bus.req_valid_i   = 1'b1;
    bus.req_wr_rd_i   = wr;
    bus.req_addr_i    = addr;
    bus.req_wr_data_i = data;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.req_ready_o) ok = 1'b1;
      @(negedge clk);
    end
    bus.req_valid_i = 1'b0;
    if (!ok) check("push_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (bus.count_o == 0 && fsm_state == IDLE) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) check("drain_timeout", 32'(0), 32'(1));
    repeat (2) @(negedge clk);
    check("drain_rsp_left", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic clear_log();
    fire_cyc.delete();
    fire_addr.delete();
    fire_wr.delete();
    fire_data.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.req_valid_i   = 1'b0;
    bus.req_wr_rd_i   = 1'b0;
    bus.req_addr_i    = '0;
    bus.req_wr_data_i = '0;
    bus.mem_ready_i   = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready_o), 32'(1));
    check("rst_mem_valid", 32'(bus.mem_valid_o), 32'(0));
    check("rst_mem_addr",  32'(bus.mem_addr_o),  32'(0));
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'(0));
    check("rst_rsp_data",  32'(bus.rsp_data_o),  32'(0));
    check("rst_count",     32'(bus.count_o),     32'(0));
    check("rst_state",     32'(fsm_state),       32'(IDLE));
    rst = 1'b1;
    @(negedge clk);

    // Single write then read of the same address
    bus.mem_ready_i = 1'b1;
    push_req(WR, 4'd3, 16'hA5A5);
    push_req(RD, 4'd3, 16'h0000);
    exp_q.push_back({4'd3, 16'hA5A5});
    wait_drain();
    check("t1_rsp_cnt", 32'(rsp_cnt), 32'(1));
    check("t1_count",   32'(bus.count_o), 32'(0));

    // Fill with memory stalled; fifth request must be refused
    bus.mem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_req(WR, 4'(8 + i), 16'hB000 + 16'(i));
    check("t2_count_full", 32'(bus.count_o),     32'(4));
    check("t2_ready_low",  32'(bus.req_ready_o), 32'(0));
    check("t2_mem_valid",  32'(bus.mem_valid_o), 32'(1));
    check("t2_head_addr",  32'(bus.mem_addr_o),  32'(8));
    bus.req_valid_i   = 1'b1;
    bus.req_wr_rd_i   = WR;
    bus.req_addr_i    = 4'd12;
    bus.req_wr_data_i = 16'hEEEE;
    repeat (2) @(negedge clk);
    check("t2_count_hold", 32'(bus.count_o),       32'(4));
    check("t2_head_stable", 32'(bus.mem_addr_o),   32'(8));
    check("t2_head_wr",    32'(bus.mem_wr_rd_o),   32'(1));
    check("t2_head_data",  32'(bus.mem_wr_data_o), 32'hB000);
    bus.req_valid_i = 1'b0;
    bus.mem_ready_i = 1'b1;
    wait_drain();
    push_req(RD, 4'd12, 16'h0000);
    exp_q.push_back({4'd12, 16'h100C});
    push_req(RD, 4'd11, 16'h0000);
    exp_q.push_back({4'd11, 16'hB003});
    wait_drain();

    // Backpressure with a read at the head
    bus.mem_ready_i = 1'b0;
    push_req(RD, 4'd9, 16'h0000);
    check("t3_valid_latency", 32'(bus.mem_valid_o), 32'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(bus.mem_valid_o),   32'(1));
      check("t3_hold_addr",  32'(bus.mem_addr_o),    32'(9));
      check("t3_hold_rd",    32'(bus.mem_wr_rd_o),   32'(0));
      check("t3_rd_wdata",   32'(bus.mem_wr_data_o), 32'(0));
      check("t3_no_rsp",     32'(bus.rsp_valid_o),   32'(0));
    end
    exp_q.push_back({4'd9, 16'hB001});
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    check("t3_wait_valid", 32'(bus.mem_valid_o), 32'(0));
    check("t3_wait_rsp",   32'(bus.rsp_valid_o), 32'(0));
    @(negedge clk);
    check("t3_rsp_valid",  32'(bus.rsp_valid_o), 32'(1));
    check("t3_rsp_data",   32'(bus.rsp_data_o),  32'hB001);
    @(negedge clk);
    check("t3_rsp_pulse",  32'(bus.rsp_valid_o), 32'(0));
    wait_drain();

    // Back-to-back writes
    clear_log();
    for (int i = 0; i < 3; i++) push_req(WR, 4'(i), 16'hC000 + 16'(i));
    wait_drain();
    check("t4_pops",   32'(fire_addr.size()), 32'(3));
    check("t4_addr0",  32'(fire_addr[0]), 32'(0));
    check("t4_addr1",  32'(fire_addr[1]), 32'(1));
    check("t4_addr2",  32'(fire_addr[2]), 32'(2));
    check("t4_data2",  32'(fire_data[2]), 32'hC002);
    check("t4_b2b_1",  32'(fire_cyc[1] - fire_cyc[0]), 32'(1));
    check("t4_b2b_2",  32'(fire_cyc[2] - fire_cyc[1]), 32'(1));
    check("t4_count",  32'(bus.count_o), 32'(0));

    // Read then write to the same address
    clear_log();
    push_req(RD, 4'd5, 16'h0000);
    exp_q.push_back({4'd5, 16'h1005});
    push_req(WR, 4'd5, 16'h1234);
    wait_drain();
    check("t5_pops",       32'(fire_wr.size()), 32'(2));
    check("t5_first_rd",   32'(fire_wr[0]), 32'(0));
    check("t5_second_wr",  32'(fire_wr[1]), 32'(1));
    check("t5_wr_after_rsp", 32'(fire_cyc[1] >= rsp_cyc), 32'(1));
    push_req(RD, 4'd5, 16'h0000);
    exp_q.push_back({4'd5, 16'h1234});
    wait_drain();

    // Reset while waiting on read data, with a write still queued
    push_req(RD, 4'd3, 16'h0000);
    push_req(WR, 4'd7, 16'hD00D);
    for (int i = 0; i < 20 && fsm_state != RD_WAIT; i++) @(negedge clk);
    check("t6_in_rd_wait", 32'(fsm_state), 32'(RD_WAIT));
    check("t6_queued",     32'(bus.count_o), 32'(1));
    begin
      int rsp_before;
      rsp_before = rsp_cnt;
      rst = 1'b0;
      #1;
      check("t6_rst_state", 32'(fsm_state),       32'(IDLE));
      check("t6_rst_count", 32'(bus.count_o),     32'(0));
      check("t6_rst_ready", 32'(bus.req_ready_o), 32'(1));
      check("t6_rst_valid", 32'(bus.mem_valid_o), 32'(0));
      check("t6_rst_rsp",   32'(bus.rsp_valid_o), 32'(0));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      clear_log();
      repeat (4) @(negedge clk);
      check("t6_no_rsp",     32'(rsp_cnt - rsp_before), 32'(0));
      check("t6_no_issue",   32'(fire_cyc.size()), 32'(0));
      check("t6_count_post", 32'(bus.count_o), 32'(0));
    end
    push_req(RD, 4'd7, 16'h0000);
    exp_q.push_back({4'd7, 16'h1007});
    wait_drain();

    check("rsp_total", 32'(rsp_cnt), 32'(7));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
